// File: rtl/drink_pkg.sv
// Shared constants, state encoding and code decoding for the drink dispenser.
package drink_pkg;
  localparam int NUM_DRINKS = 3;

  localparam logic [2:0] CODE_D0   = 3'b110;
  localparam logic [2:0] CODE_D1   = 3'b101;
  localparam logic [2:0] CODE_D2   = 3'b011;
  localparam logic [2:0] CODE_IDLE = 3'b111;

  typedef enum logic [1:0] {IDLE, POUR, WAIT_REL, ERR} state_t;

  // Drink index for a panel code; 3 marks "not a drink" (idle or invalid).
  function automatic logic [1:0] code_to_idx(input logic [2:0] code);
    case (code)
      CODE_D0: code_to_idx = 2'd0;
      CODE_D1: code_to_idx = 2'd1;
      CODE_D2: code_to_idx = 2'd2;
      default: code_to_idx = 2'd3;
    endcase
  endfunction
endpackage

// File: rtl/code_stabilizer.sv
// Two-flop synchronizer for the panel code plus a hold counter that flags
// the synchronized code as stable once it has held STABLE_CYCLES cycles.
module code_stabilizer import drink_pkg::*; #(
  parameter int STABLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] sel_n,
  output logic [2:0] code,
  output logic       stable
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);

  logic [2:0]    meta;
  logic [CW-1:0] cnt;

  // cnt is the number of cycles the current synchronized code has been held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= CODE_IDLE;
      code <= CODE_IDLE;
      cnt  <= '0;
    end else begin
      meta <= sel_n;
      code <= meta;
      if (meta != code)
        cnt <= CW'(1);
      else if (cnt != CW'(STABLE_CYCLES))
        cnt <= cnt + 1'b1;
    end
  end

  assign stable = (cnt == CW'(STABLE_CYCLES));
endmodule

// File: rtl/drink_dispenser.sv
// Drink dispenser controller. Define DRINK_DISPENSER_STOCK_EN to enable
// per-drink stock counting, the empty flags and the out-of-stock error path.
module drink_dispenser import drink_pkg::*; #(
  parameter int STABLE_CYCLES = 16,
  parameter int POUR_CYCLES   = 50_000_000,
  parameter int STOCK_INIT    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] sel_n,
  input  logic       refill,
  output logic [2:0] valve,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] empty
);
  localparam int TW = (POUR_CYCLES > 1) ? $clog2(POUR_CYCLES) : 1;

  logic [2:0]    code;
  logic          stable;
  state_t        state;
  logic [1:0]    idx;
  logic [TW-1:0] timer;
  logic [1:0]    sel_idx;
  logic          sel_drink;
  logic          sel_empty;
  logic          rel;

  code_stabilizer #(.STABLE_CYCLES(STABLE_CYCLES)) u_stab (
    .clk    (clk),
    .rst_n  (rst_n),
    .sel_n  (sel_n),
    .code   (code),
    .stable (stable)
  );

  assign sel_idx   = code_to_idx(code);
  assign sel_drink = (sel_idx != 2'd3);
  assign rel       = stable && (code == CODE_IDLE);

`ifdef DRINK_DISPENSER_STOCK_EN
  localparam int SW = (STOCK_INIT > 0) ? $clog2(STOCK_INIT + 1) : 1;
  logic [NUM_DRINKS-1:0][SW-1:0] stock;

  always_comb begin
    sel_empty = 1'b0;
    for (int i = 0; i < NUM_DRINKS; i++) begin
      empty[i] = (stock[i] == '0);
      if (sel_idx == 2'(i)) sel_empty = (stock[i] == '0);
    end
  end
`else
  logic unused_refill;
  assign unused_refill = refill ^ (STOCK_INIT > 0);
  assign sel_empty     = 1'b0;
  assign empty         = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      timer <= '0;
      valve <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
`ifdef DRINK_DISPENSER_STOCK_EN
      stock <= {NUM_DRINKS{SW'(STOCK_INIT)}};
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (stable) begin
          if (sel_drink && !sel_empty) begin
            state <= POUR;
            idx   <= sel_idx;
            timer <= '0;
            valve <= 3'b001 << sel_idx;
            busy  <= 1'b1;
          end else if (code != CODE_IDLE) begin
            state <= ERR;
            err   <= 1'b1;
          end
        end
        // A release abort takes priority over completion on the same cycle.
        POUR: if (rel) begin
          state <= IDLE;
          valve <= '0;
          busy  <= 1'b0;
        end else if (timer == TW'(POUR_CYCLES - 1)) begin
          state <= WAIT_REL;
          valve <= '0;
          busy  <= 1'b0;
          done  <= 1'b1;
`ifdef DRINK_DISPENSER_STOCK_EN
          for (int i = 0; i < NUM_DRINKS; i++)
            if (idx == 2'(i) && stock[i] != '0) stock[i] <= stock[i] - 1'b1;
`endif
        end else begin
          timer <= timer + 1'b1;
        end
        WAIT_REL, ERR: if (rel) begin
          state <= IDLE;
          err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
`ifdef DRINK_DISPENSER_STOCK_EN
      if (refill) stock <= {NUM_DRINKS{SW'(STOCK_INIT)}};
`endif
    end
  end
endmodule

// File: tb/tb_drink_dispenser.sv
// Directed bench for drink_dispenser with STABLE_CYCLES=4, POUR_CYCLES=8, STOCK_INIT=2.
module tb_drink_dispenser;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] sel_n = 3'b111;
  logic       refill = 1'b0;
  logic [2:0] valve, empty;
  logic       busy, done, err;

  int nchk = 0, nfail = 0;
  int cyc, valve_cyc, done_cnt, done_at, first_valve, bad_busy, bad_hot;
  logic [2:0] valve_seen;
  logic       err_seen;

  drink_dispenser #(.STABLE_CYCLES(4), .POUR_CYCLES(8), .STOCK_INIT(2)) dut (
    .clk(clk), .rst_n(rst_n), .sel_n(sel_n), .refill(refill),
    .valve(valve), .busy(busy), .done(done), .err(err), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic clr();
    cyc = 0; valve_cyc = 0; done_cnt = 0; done_at = -1; first_valve = -1;
    bad_busy = 0; bad_hot = 0; valve_seen = '0; err_seen = 1'b0;
  endtask

  // Advance n cycles, sampling 1 time unit after each rising edge.
  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      cyc++;
      if (valve != 3'b000) begin
        valve_cyc++;
        valve_seen = valve_seen | valve;
        if (first_valve < 0) first_valve = cyc;
      end
      if (done) begin done_cnt++; if (done_at < 0) done_at = cyc; end
      if (busy !== (valve != 3'b000)) bad_busy++;
      if ((valve & (valve - 3'b001)) != 3'b000) bad_hot++;
      if (err) err_seen = 1'b1;
    end
  endtask

  task automatic pulse_refill();
    refill = 1'b1; run(1); refill = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sel_n = 3'b111;
    #2;
    nchk++; if (valve !== 3'b000) begin nfail++; $display("FAIL reset_valve: got %b want 000", valve); end
    nchk++; if ({busy, done, err} !== 3'b000) begin nfail++; $display("FAIL reset_flags: got busy/done/err %b want 000", {busy, done, err}); end
    nchk++; if (empty !== 3'b000) begin nfail++; $display("FAIL reset_empty: got %b want 000", empty); end
    @(posedge clk); #1; rst_n = 1'b1;
    clr(); run(6);
    nchk++; if (valve_cyc !== 0 || err_seen !== 1'b0) begin nfail++; $display("FAIL reset_idle: valve cycles %0d err %b want 0 0", valve_cyc, err_seen); end
  endtask

  task automatic test_pour();
    sel_n = 3'b101; clr(); run(30);
    nchk++; if (first_valve !== 6) begin nfail++; $display("FAIL pour_latency: got %0d want 6", first_valve); end
    nchk++; if (valve_cyc !== 8) begin nfail++; $display("FAIL pour_len: got %0d want 8", valve_cyc); end
    nchk++; if (valve_seen !== 3'b010) begin nfail++; $display("FAIL pour_valve: got %b want 010", valve_seen); end
    nchk++; if (done_cnt !== 1 || done_at !== 14) begin nfail++; $display("FAIL pour_done: count %0d at %0d want 1 at 14", done_cnt, done_at); end
    nchk++; if (bad_busy !== 0 || bad_hot !== 0) begin nfail++; $display("FAIL pour_busy_onehot: busy errs %0d hot errs %0d want 0 0", bad_busy, bad_hot); end
    // Three cycles of idle is too short to release WAIT_REL.
    sel_n = 3'b111; run(3);
    sel_n = 3'b101; clr(); run(20);
    nchk++; if (valve_cyc !== 0 || done_cnt !== 0) begin nfail++; $display("FAIL wait_rel_hold: valve cycles %0d dones %0d want 0 0", valve_cyc, done_cnt); end
  endtask

  task automatic test_back_to_back();
    sel_n = 3'b111; clr(); run(8);
    sel_n = 3'b101; run(30);
    nchk++; if (valve_cyc !== 8 || done_cnt !== 1) begin nfail++; $display("FAIL repour: valve cycles %0d dones %0d want 8 1", valve_cyc, done_cnt); end
    sel_n = 3'b111; run(8);
  endtask

  task automatic test_glitch();
    sel_n = 3'b110; clr(); run(3);
    sel_n = 3'b111; run(20);
    nchk++; if (valve_cyc !== 0 || err_seen !== 1'b0 || done_cnt !== 0) begin nfail++; $display("FAIL glitch: valve cycles %0d err %b dones %0d want 0 0 0", valve_cyc, err_seen, done_cnt); end
  endtask

  task automatic test_abort();
    pulse_refill();
    sel_n = 3'b011; clr();
    while (valve_cyc < 3 && cyc < 20) run(1);
    nchk++; if (valve_cyc !== 3) begin nfail++; $display("FAIL abort_start: valve cycles %0d want 3", valve_cyc); end
    sel_n = 3'b111; run(20);
    nchk++; if (valve_cyc !== 8 || valve_seen !== 3'b100) begin nfail++; $display("FAIL abort_valve: cycles %0d seen %b want 8 100", valve_cyc, valve_seen); end
    nchk++; if (done_cnt !== 0 || valve !== 3'b000) begin nfail++; $display("FAIL abort_done: dones %0d valve %b want 0 000", done_cnt, valve); end
    sel_n = 3'b011; clr(); run(30);
    sel_n = 3'b111; run(8);
    nchk++; if (done_cnt !== 1 || empty !== 3'b000) begin nfail++; $display("FAIL abort_stock: dones %0d empty %b want 1 000", done_cnt, empty); end
  endtask

  task automatic test_invalid();
    sel_n = 3'b100; clr(); run(5);
    nchk++; if (err !== 1'b0) begin nfail++; $display("FAIL invalid_early: err %b want 0", err); end
    run(1);
    nchk++; if (err !== 1'b1) begin nfail++; $display("FAIL invalid_err: err %b want 1", err); end
    run(6);
    sel_n = 3'b111; run(5);
    nchk++; if (err !== 1'b1) begin nfail++; $display("FAIL invalid_hold: err %b want 1", err); end
    run(1);
    nchk++; if (err !== 1'b0 || valve_cyc !== 0) begin nfail++; $display("FAIL invalid_clear: err %b valve cycles %0d want 0 0", err, valve_cyc); end
  endtask

`ifdef DRINK_DISPENSER_STOCK_EN
  task automatic test_stock();
    pulse_refill();
    sel_n = 3'b110; clr(); run(30); sel_n = 3'b111; run(8);
    nchk++; if (done_cnt !== 1 || empty !== 3'b000) begin nfail++; $display("FAIL stock_first: dones %0d empty %b want 1 000", done_cnt, empty); end
    sel_n = 3'b110; clr(); run(30); sel_n = 3'b111; run(8);
    nchk++; if (done_cnt !== 1 || empty !== 3'b001) begin nfail++; $display("FAIL stock_second: dones %0d empty %b want 1 001", done_cnt, empty); end
    sel_n = 3'b110; clr(); run(12);
    nchk++; if (err !== 1'b1 || valve_cyc !== 0) begin nfail++; $display("FAIL stock_empty_err: err %b valve cycles %0d want 1 0", err, valve_cyc); end
    sel_n = 3'b111; run(8);
    pulse_refill();
    nchk++; if (empty !== 3'b000 || err !== 1'b0) begin nfail++; $display("FAIL stock_refill: empty %b err %b want 000 0", empty, err); end
    // Refill on the completion cycle must leave the counter full.
    sel_n = 3'b110; clr(); run(13);
    refill = 1'b1; run(1); refill = 1'b0;
    sel_n = 3'b111; run(8);
    sel_n = 3'b110; run(30); sel_n = 3'b111; run(8);
    nchk++; if (done_cnt !== 2 || empty !== 3'b000) begin nfail++; $display("FAIL stock_refill_wins: dones %0d empty %b want 2 000", done_cnt, empty); end
  endtask
`else
  task automatic test_stock();
    clr();
    for (int p = 0; p < 3; p++) begin
      sel_n = 3'b110; run(30); sel_n = 3'b111; run(8);
    end
    nchk++; if (done_cnt !== 3 || err_seen !== 1'b0) begin nfail++; $display("FAIL nostock_pours: dones %0d err %b want 3 0", done_cnt, err_seen); end
    pulse_refill();
    nchk++; if (empty !== 3'b000) begin nfail++; $display("FAIL nostock_empty: empty %b want 000", empty); end
  endtask
`endif

  task automatic test_reset_mid_pour();
    pulse_refill();
    sel_n = 3'b101; clr(); run(8);
    nchk++; if (valve !== 3'b010) begin nfail++; $display("FAIL rst_pre: valve %b want 010", valve); end
    rst_n = 1'b0; sel_n = 3'b111; #1;
    nchk++; if (valve !== 3'b000 || busy !== 1'b0 || done !== 1'b0) begin nfail++; $display("FAIL rst_async: valve %b busy %b done %b want 000 0 0", valve, busy, done); end
    @(posedge clk); #1; rst_n = 1'b1;
    clr(); run(10);
    nchk++; if (valve_cyc !== 0 || done_cnt !== 0 || err_seen !== 1'b0) begin nfail++; $display("FAIL rst_after: valve cycles %0d dones %0d err %b want 0 0 0", valve_cyc, done_cnt, err_seen); end
    sel_n = 3'b101; clr(); run(30);
    nchk++; if (valve_cyc !== 8 || done_cnt !== 1) begin nfail++; $display("FAIL rst_idle_pour: valve cycles %0d dones %0d want 8 1", valve_cyc, done_cnt); end
    sel_n = 3'b111; run(8);
  endtask

  initial begin
    test_reset();
    test_pour();
    test_back_to_back();
    test_glitch();
    test_abort();
    test_invalid();
    test_stock();
    test_reset_mid_pour();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
